// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Purpose  : Transmit side of the common data bus. Buffers add-RS and
//             load-unit results in small per-source FIFOs and broadcasts one
//             result per cycle on a registered CDB, round-robin between the
//             two sources. A ROB flush discards every pending result.
//  Revision : 1.0  initial release
// ============================================================================
module cdb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH  = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  addValid,
    input  logic [ROB_WIDTH-1:0]  addRobNum,
    input  logic [DATA_WIDTH-1:0] addData,
    output logic                  addReady,
    input  logic                  loadValid,
    input  logic [ROB_WIDTH-1:0]  loadRobNum,
    input  logic [DATA_WIDTH-1:0] loadData,
    output logic                  loadReady,
    input  logic                  flush,
    output logic                  iscast_out,
    output logic [ROB_WIDTH-1:0]  robNum_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  grantSrc
);

    localparam int c_ENTRY_W = ROB_WIDTH + DATA_WIDTH;
    localparam int c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W   = $clog2(FIFO_DEPTH + 1);

    // Source 0 is the add RS, source 1 is the load unit.
    logic [1:0]           w_in_valid;
    logic [c_ENTRY_W-1:0] w_in_entry [2];
    logic [c_ENTRY_W-1:0] w_head     [2];
    logic [1:0]           w_full;
    logic [1:0]           w_empty;
    logic [1:0]           w_push;
    logic [1:0]           w_pop;
    logic                 w_any;
    logic                 w_sel;

    logic                  r_prio;
    logic                  r_cast;
    logic [ROB_WIDTH-1:0]  r_rob;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_grant;

    assign w_in_valid    = {loadValid, addValid};
    assign w_in_entry[0] = {addRobNum, addData};
    assign w_in_entry[1] = {loadRobNum, loadData};

    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
        logic [c_PTR_W-1:0]   r_wptr;
        logic [c_PTR_W-1:0]   r_rptr;
        logic [c_CNT_W-1:0]   r_cnt;

        assign w_full[gi]  = (r_cnt == c_CNT_W'(FIFO_DEPTH));
        assign w_empty[gi] = (r_cnt == '0);
        assign w_head[gi]  = r_mem[r_rptr];
        // Flush swallows any push offered in the same cycle.
        assign w_push[gi]  = w_in_valid[gi] & ~w_full[gi] & ~flush;
        assign w_pop[gi]   = w_any & ~flush & (w_sel == 1'(gi));

        // Pointer and occupancy bookkeeping; flush empties the FIFO outright.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
            end else if (flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
            end else begin
                if (w_push[gi]) r_wptr <= next_ptr(r_wptr);
                if (w_pop[gi])  r_rptr <= next_ptr(r_rptr);
                case ({w_push[gi], w_pop[gi]})
                    2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
                    2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

        // Storage array needs no reset: occupancy alone marks valid entries.
        always_ff @(posedge clock) begin
            if (w_push[gi]) r_mem[r_wptr] <= w_in_entry[gi];
        end
    end

    // Grant the only non-empty source, or the preferred one when both contend.
    always_comb begin
        w_sel = r_prio;
        if (w_empty[0])      w_sel = 1'b1;
        else if (w_empty[1]) w_sel = 1'b0;
    end

    assign w_any = ~&w_empty;

    // Registered CDB broadcast and round-robin preference (moves only on a grant).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prio  <= 1'b0;
            r_cast  <= 1'b0;
            r_rob   <= '0;
            r_data  <= '0;
            r_grant <= 1'b0;
        end else if (flush) begin
            r_cast  <= 1'b0;
        end else if (w_any) begin
            r_cast  <= 1'b1;
            r_rob   <= w_head[w_sel][c_ENTRY_W-1:DATA_WIDTH];
            r_data  <= w_head[w_sel][DATA_WIDTH-1:0];
            r_grant <= w_sel;
            r_prio  <= ~w_sel;
        end else begin
            r_cast  <= 1'b0;
        end
    end

    assign addReady   = ~w_full[0];
    assign loadReady  = ~w_full[1];
    assign iscast_out = r_cast;
    assign robNum_out = r_rob;
    assign data_out   = r_data;
    assign grantSrc   = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdb_arbiter
//  Purpose  : Self-checking bench for cdb_arbiter with a queue-based
//             reference model of the two source FIFOs and the arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int DW    = 32;
    localparam int RW    = 3;
    localparam int DEPTH = 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          addValid = 1'b0;
    logic [RW-1:0] addRobNum = '0;
    logic [DW-1:0] addData = '0;
    logic          addReady;
    logic          loadValid = 1'b0;
    logic [RW-1:0] loadRobNum = '0;
    logic [DW-1:0] loadData = '0;
    logic          loadReady;
    logic          flush = 1'b0;
    logic          iscast_out;
    logic [RW-1:0] robNum_out;
    logic [DW-1:0] data_out;
    logic          grantSrc;

    always #5 clock = ~clock;

    cdb_arbiter #(.DATA_WIDTH(DW), .ROB_WIDTH(RW), .FIFO_DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .addValid   (addValid),
        .addRobNum  (addRobNum),
        .addData    (addData),
        .addReady   (addReady),
        .loadValid  (loadValid),
        .loadRobNum (loadRobNum),
        .loadData   (loadData),
        .loadReady  (loadReady),
        .flush      (flush),
        .iscast_out (iscast_out),
        .robNum_out (robNum_out),
        .data_out   (data_out),
        .grantSrc   (grantSrc)
    );

    int nvec = 0;
    int nerr = 0;

    // Model state: expected FIFO contents and expected CDB registers.
    logic [RW+DW-1:0] qa[$];
    logic [RW+DW-1:0] ql[$];
    logic             m_prio;
    logic             e_cast;
    logic [RW-1:0]    e_rob;
    logic [DW-1:0]    e_data;
    logic             e_grant;
    logic             took_a, took_l;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        ql.delete();
        m_prio  = 1'b0;
        e_cast  = 1'b0;
        e_rob   = '0;
        e_data  = '0;
        e_grant = 1'b0;
    endtask

    task automatic drive(input logic av, input logic [RW-1:0] ar, input logic [DW-1:0] ad,
                         input logic lv, input logic [RW-1:0] lr, input logic [DW-1:0] ld,
                         input logic fl);
        addValid = av;  addRobNum = ar;  addData = ad;
        loadValid = lv; loadRobNum = lr; loadData = ld;
        flush = fl;
    endtask

    // One clock: check readies, advance the model, then compare the CDB.
    task automatic tick();
        logic ra, rl, g, has;
        logic [RW+DW-1:0] item;
        ra = (qa.size() < DEPTH);
        rl = (ql.size() < DEPTH);
        check("addReady", addReady, ra);
        check("loadReady", loadReady, rl);
        took_a = addValid && (ra || flush);
        took_l = loadValid && (rl || flush);
        if (flush) begin
            qa.delete();
            ql.delete();
            e_cast = 1'b0;
        end else begin
            has = 1'b1;
            g   = 1'b0;
            if (qa.size() > 0 && ql.size() > 0) g = m_prio;
            else if (qa.size() > 0)              g = 1'b0;
            else if (ql.size() > 0)              g = 1'b1;
            else                                 has = 1'b0;
            if (has) begin
                item    = g ? ql.pop_front() : qa.pop_front();
                e_cast  = 1'b1;
                e_rob   = item[RW+DW-1:DW];
                e_data  = item[DW-1:0];
                e_grant = g;
                m_prio  = ~g;
            end else begin
                e_cast = 1'b0;
            end
            if (addValid && ra)  qa.push_back({addRobNum, addData});
            if (loadValid && rl) ql.push_back({loadRobNum, loadData});
        end
        @(posedge clock);
        #1;
        check("iscast", iscast_out, e_cast);
        check("robNum", robNum_out, e_rob);
        check("data", data_out, e_data);
        check("grantSrc", grantSrc, e_grant);
    endtask

    initial begin
        int idx;
        logic saw_low;
        logic [RW-1:0] ar;
        logic [DW-1:0] ad;

        // Reset held with valids high: nothing stored, outputs idle.
        model_reset();
        drive(1'b1, 3'd5, 32'hAAAA_0001, 1'b1, 3'd6, 32'hBBBB_0001, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        check("rst_iscast", iscast_out, 1'b0);
        check("rst_robNum", robNum_out, '0);
        check("rst_data", data_out, '0);
        check("rst_grant", grantSrc, 1'b0);
        check("rst_addReady", addReady, 1'b1);
        check("rst_loadReady", loadReady, 1'b1);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Contention straight after reset: add wins, then load.
        drive(1'b1, 3'd1, 32'h11, 1'b1, 3'd2, 32'h22, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        tick();
        check("cont1_first_src", grantSrc, 1'b0);
        tick();
        check("cont1_second_src", grantSrc, 1'b1);
        tick();

        // Single add result.
        drive(1'b1, 3'd3, 32'h0000_002A, 1'b0, '0, '0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        tick();
        check("single_cast", iscast_out, 1'b1);
        check("single_rob", robNum_out, 3'd3);
        check("single_data", data_out, 32'h2A);
        tick();
        check("single_pulse_end", iscast_out, 1'b0);

        // Contention with the pointer now favouring load: load first.
        drive(1'b1, 3'd4, 32'h44, 1'b1, 3'd7, 32'h77, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        tick();
        check("cont2_first_src", grantSrc, 1'b1);
        repeat (2) tick();

        // Back-pressure: three add results held until taken, load streaming.
        idx = 0;
        saw_low = 1'b0;
        for (int c = 0; c < 14; c++) begin
            ar = RW'(4 + idx);
            ad = 32'hA0 + DW'(idx);
            drive(idx < 3, ar, ad, c < 6, RW'(c), 32'hB0 + DW'(c), 1'b0);
            if (!addReady) saw_low = 1'b1;
            tick();
            if (took_a) idx++;
        end
        check("bp_ready_dropped", saw_low, 1'b1);
        check("bp_all_taken", idx, 3);

        // Flush with both FIFOs loaded and an add offered in the flush cycle.
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, RW'(c), 32'hC0 + DW'(c), 1'b1, RW'(c + 4), 32'hD0 + DW'(c), 1'b0);
            tick();
        end
        drive(1'b1, 3'd7, 32'hDEAD, 1'b0, '0, '0, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        repeat (4) tick();
        check("flush_addReady", addReady, 1'b1);
        check("flush_loadReady", loadReady, 1'b1);

        // Asynchronous reset between edges with entries pending.
        drive(1'b1, 3'd1, 32'hE1, 1'b1, 3'd2, 32'hE2, 1'b0);
        tick();
        drive(1'b1, 3'd3, 32'hE3, 1'b1, 3'd4, 32'hE4, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("arst_iscast", iscast_out, 1'b0);
        check("arst_robNum", robNum_out, '0);
        check("arst_data", data_out, '0);
        check("arst_grant", grantSrc, 1'b0);
        check("arst_addReady", addReady, 1'b1);
        check("arst_loadReady", loadReady, 1'b1);
        #2;
        reset_n = 1'b1;
        repeat (3) tick();

        // Random traffic; sources hold a result until it is taken.
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        for (int c = 0; c < 80; c++) begin
            if (!addValid && $urandom_range(0, 2) != 0) begin
                addValid = 1'b1; addRobNum = RW'($urandom); addData = $urandom;
            end
            if (!loadValid && $urandom_range(0, 2) != 0) begin
                loadValid = 1'b1; loadRobNum = RW'($urandom); loadData = $urandom;
            end
            flush = ($urandom_range(0, 15) == 0);
            tick();
            if (took_a) addValid = 1'b0;
            if (took_l) loadValid = 1'b0;
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
